// File: rtl/gf_pkg.sv
// Shared constants and sizing helper for the GF(2^n) arithmetic blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gf_pkg;

  // Low bits of the AES field polynomial x^8+x^4+x^3+x+1 (x^8 implicit).
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Low bits of the GF(16) polynomial x^4+x+1 (x^4 implicit).
  localparam logic [3:0] GF4_POLY = 4'h3;

  // Width of a counter that walks bit indices WIDTH-1 down to 0.
  function automatic int gf_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/gf_xtime_p.sv
// Multiply-by-x in GF(2^WIDTH): shift left, fold the carry back in through POLY.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module gf_xtime_p #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B
) (
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] y
);

  // The bit shifted out is the x^WIDTH term; replace it by its reduction.
  assign y = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/gf_mult_seq.sv
// Iterative GF(2^WIDTH) multiplier, MSB-first Horner shift-and-add, one bit of b per clock.
// Latency: WIDTH cycles from the accepting edge to done; one result per WIDTH cycles.
// Backpressure: start is ignored while busy=1; a start in the done cycle is accepted.
module gf_mult_seq
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = gf_cnt_w(WIDTH);

  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_x;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;

  gf_xtime_p #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_xtime (
    .v (acc),
    .y (acc_x)
  );

  // One Horner step: acc*x plus a if the current multiplier bit is set.
  always_comb begin
    acc_nxt = acc_x ^ (br[cnt] ? ar : '0);
  end

  // busy is the whole state: IDLE waits for start, RUN consumes b from MSB to LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      ar      <= '0;
      br      <= '0;
      cnt     <= '0;
    end else if (!busy) begin
      done <= 1'b0;
      if (start) begin
        ar   <= a;
        br   <= b;
        acc  <= '0;
        cnt  <= CNT_W'(WIDTH - 1);
        busy <= 1'b1;
      end
    end else begin
      acc <= acc_nxt;
      if (cnt == '0) begin
        // Last bit consumed: publish and drop back to IDLE so a new start lands next edge.
        product <= acc_nxt;
        done    <= 1'b1;
        busy    <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/gf_mult_seq.md
Name: gf_mult_seq

Overview:
- Iterative GF(2^WIDTH) multiplier with a start/done handshake.
- Generalises the combinational multiply-by-x (xtime) stage to any field width and reduction polynomial.
- Computes a full product a·b by MSB-first Horner shift-and-add, one bit of b per clock.
- Used by the AES datapath (MixColumns, key schedule) wherever area matters more than throughput.

Parameters:
- WIDTH, 8, field width in bits; legal range 2..16.
- POLY, 8'h1B, low WIDTH bits of the reduction polynomial. The x^WIDTH term is implicit. Default is the AES polynomial x^8+x^4+x^3+x+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only while busy=0.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when product becomes valid.
- product  output  WIDTH  result; held stable until the next completion or reset.

Behaviour:
- Reset (rst=1 at a clock edge) clears busy, done, product, the internal accumulator, the a/b registers and the bit counter to 0. Reset overrides everything else, including an operation in progress.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1 at an edge:
  - latch a→ar, b→br; acc←0; cnt←WIDTH-1; busy←1; done←0.
- IDLE, start=0:
  - hold all registers; done←0.
- RUN, every edge:
  - acc ← xtime(acc) XOR (br[cnt] ? ar : 0).
  - If cnt==0: product←new acc value; done←1; busy←0 (→IDLE).
  - Otherwise: cnt←cnt-1.
- xtime(v) = (v<<1)[WIDTH-1:0] XOR (v[WIDTH-1] ? POLY : 0).
- Latency:
  - Start accepted at edge E0; done=1 and product valid after edge E0+WIDTH.
  - That is WIDTH cycles, e.g. 8 cycles for WIDTH=8.
  - Throughput is one result per WIDTH cycles.
- done is high for exactly one cycle per completion, never during reset, and never without a preceding accepted start.
- start while busy=1 is ignored: no effect on ar, br, acc or cnt, and not queued.
- start in the same cycle that done=1: busy is already 0, so it is accepted. This gives back-to-back operations with no idle cycle.
- Inputs a and b may change freely after acceptance; the result depends only on the values captured at acceptance.
- product keeps its last value while a new operation runs. It changes only at the completion edge.
- Operand 0 and operand 1 need no special-casing; the datapath handles them naturally.

Decomposition:
- Package gf_pkg:
  - constants AES_POLY=8'h1B and GF4_POLY=4'h3;
  - localparam helper CNT_W = $clog2(WIDTH).
- One sub-module, gf_xtime_p (WIDTH, POLY): purely combinational parametrised xtime, instantiated once on the accumulator path.
- The state is a single busy bit; no separate FSM module.

Test Plan:
1. Reset, then start with a=8'h57, b=8'h83 (defaults) → done exactly 8 cycles after the accepting edge; product=8'hC1; busy high for those 8 cycles.
2. Back-to-back operations:
   - a=8'h57, b=8'h13 → product=8'hFE.
   - start asserted again in the done cycle with a=8'h57, b=8'h02 → product=8'hAE, done 8 cycles later, no gap cycle.
   - Then a=8'hAE, b=8'h02 → 8'h47.
3. Start held high and a/b toggled throughout a RUN (a=8'h57, b=8'h01 accepted first) → product=8'h57. Exactly one done pulse per operation; the mid-run starts are ignored.
4. Zero and identity cases:
   - a=8'h00, b=8'hFF → product=8'h00.
   - a=8'hFF, b=8'h01 → product=8'hFF.
   - a=8'h01, b=8'hCA → product=8'hCA.
5. Assert rst at cycle 3 of a RUN → next cycle busy=0, done=0, product=0; no done pulse follows. A fresh start after reset then computes 8'h57·8'h83=8'hC1 correctly.
6. Instance with WIDTH=4, POLY=4'h3:
   - a=4'h2, b=4'h8 → product=4'h3 after 4 cycles.
   - a=4'hF, b=4'hF → product=4'hA.
